line_buf_writer: RTL



---
 rtl/line_buf_writer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/line_buf_writer.sv
// -----------------------------------------------------------------------------
// line_buf_writer
//
// Producer side of the 4-bank line-buffer ring feeding the scaler. Each input
// line is written into one bank starting at address 0; the bank rotates after
// every completed line. Completed lines are counted against reader releases so
// that a bank the reader still owns is never overwritten, and the upstream
// stream is stalled (in_ready low) while the ring is full.
//
// Optional feature (macro EDGE_PAD_EN):
//   When defined, every line gets one extra write at address LINE_LEN that
//   duplicates the last pixel, so the reader's x+1 tap at the right edge reads
//   valid data. Requires LINE_LEN <= 2**ADDR_W-2. When undefined, no pad write.
//
// Ports:
//   clk, rstn       clock (rising edge), asynchronous active-low reset
//   frame_start     1-cycle pulse; restarts the ring at bank 4'b0001
//   in_valid/in_data/in_ready
//                   pixel stream; a beat moves when in_valid & in_ready
//   ram_select      one-hot bank being written (never changes while wr_en=1)
//   wr_addr/wr_data/wr_en
//                   registered ring write port, 1 cycle after the accepted beat
//   line_done       1-cycle pulse after the last write of a line
//   lines_avail     completed, unreleased lines (0..3)
//   rd_ok           lines_avail >= 2
//   line_release    reader pulse freeing the oldest completed line
//   err_underflow   sticky; release seen with lines_avail == 0
//   state_dbg       current FSM state (debug observability)
//
// Handshake: in_valid/in_ready follow strict valid/ready rules. A beat is
// transferred on a rising edge where both are high; upstream holds in_data
// stable while in_valid is high and in_ready is low. in_ready is registered
// and never depends combinationally on in_valid.
// -----------------------------------------------------------------------------
module line_buf_writer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 11,
    parameter int LINE_LEN = 1280
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [3:0]        ram_select,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              line_done,
    output logic [1:0]        lines_avail,
    output logic              rd_ok,
    input  logic              line_release,
    output logic              err_underflow,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_LINE_END  = 3'd2,
        S_PAD_END   = 3'd3,
        S_WAIT_BANK = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_LEN - 1);

`ifdef EDGE_PAD_EN
    localparam logic [ADDR_W-1:0] PAD_ADDR  = ADDR_W'(LINE_LEN);
    // The line is accounted for in the second end-of-line cycle.
    localparam state_t            FINAL_END = S_PAD_END;
`else
    localparam state_t            FINAL_END = S_LINE_END;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic              beat;
    logic              line_complete;
    logic              underflow_hit;
    logic [1:0]        avail_next;

    assign beat          = in_valid & in_ready;
    assign line_complete = (state == FINAL_END);
    // A release coinciding with a completion is simply absorbed, never an error.
    assign underflow_hit = line_release & ~line_complete & (lines_avail == 2'd0);
    assign rd_ok         = (lines_avail >= 2'd2);
    assign state_dbg     = state;

    // Next line count: completion and release in the same cycle cancel out.
    always_comb begin
        avail_next = lines_avail;
        case ({line_complete, line_release})
            2'b10: if (lines_avail != 2'd3) avail_next = lines_avail + 2'd1;
            2'b01: if (lines_avail != 2'd0) avail_next = lines_avail - 2'd1;
            default: avail_next = lines_avail;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            pix_cnt       <= '0;
            ram_select    <= 4'b0001;
            wr_addr       <= '0;
            wr_data       <= '0;
            wr_en         <= 1'b0;
            in_ready      <= 1'b0;
            line_done     <= 1'b0;
            lines_avail   <= 2'd0;
            err_underflow <= 1'b0;
        end else begin
            err_underflow <= err_underflow | underflow_hit;
            wr_en         <= 1'b0;
            line_done     <= 1'b0;

            if (frame_start) begin
                // Restart the ring; any partial line is abandoned.
                state       <= S_WRITE;
                in_ready    <= 1'b1;
                ram_select  <= 4'b0001;
                pix_cnt     <= '0;
                lines_avail <= 2'd0;
            end else begin
                lines_avail <= avail_next;

                case (state)
                    S_IDLE: in_ready <= 1'b0;

                    S_WRITE: begin
                        if (beat) begin
                            wr_en   <= 1'b1;
                            wr_addr <= pix_cnt;
                            wr_data <= in_data;
                            if (pix_cnt == LAST_IDX) begin
                                state    <= S_LINE_END;
                                in_ready <= 1'b0;
                            end else begin
                                pix_cnt <= pix_cnt + ADDR_W'(1);
                            end
                        end
                    end

                    S_LINE_END: begin
`ifdef EDGE_PAD_EN
                        // wr_data still holds the last pixel of the line.
                        wr_en   <= 1'b1;
                        wr_addr <= PAD_ADDR;
                        state   <= S_PAD_END;
`endif
                    end

                    S_PAD_END: ;

                    S_WAIT_BANK: begin
                        if (lines_avail <= 2'd2) begin
                            state    <= S_WRITE;
                            in_ready <= 1'b1;
                        end
                    end

                    default: begin
                        state    <= S_IDLE;
                        in_ready <= 1'b0;
                    end
                endcase

                // Close the line: rotate only after its last write has been
                // issued, so ram_select is steady under every wr_en.
                if (line_complete) begin
                    line_done  <= 1'b1;
                    ram_select <= {ram_select[2:0], ram_select[3]};
                    pix_cnt    <= '0;
                    if (avail_next <= 2'd2) begin
                        state    <= S_WRITE;
                        in_ready <= 1'b1;
                    end else begin
                        state    <= S_WAIT_BANK;
                        in_ready <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
